// File: rtl/stream_demux_pkg.sv
// Shared constants and buffer-entry layout for the 1-to-2 stream demultiplexer.
// An entry is packed as {sel, data}, with sel in the MSB, for any data width.
package stream_demux_pkg;

  localparam int DEMUX_DEPTH  = 2;
  localparam int DEMUX_DATA_W = 32;

  localparam logic SEL_OUT0 = 1'b0;
  localparam logic SEL_OUT1 = 1'b1;

  typedef struct packed {
    logic                    sel;
    logic [DEMUX_DATA_W-1:0] data;
  } demux_entry_t;

endpackage

// File: rtl/stream_demux_fifo2.sv
// Two-entry synchronous FIFO with 1-bit read/write pointers and a 0..2 count.
// Full/empty come straight from the registered count, so they carry no path from pop.
module fifo2
  import stream_demux_pkg::*;
#(
  parameter int ENTRY_W = 33
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic [ENTRY_W-1:0] push_data,
  input  logic               pop,
  output logic [ENTRY_W-1:0] head_data,
  output logic               full,
  output logic               empty
);

  logic [ENTRY_W-1:0] mem_q [DEMUX_DEPTH];
  logic [ENTRY_W-1:0] mem_d [DEMUX_DEPTH];
  logic               wr_ptr_q, wr_ptr_d;
  logic               rd_ptr_q, rd_ptr_d;
  logic [1:0]         count_q, count_d;
  logic               do_push, do_pop;

  assign full      = (count_q == 2'(DEMUX_DEPTH));
  assign empty     = (count_q == 2'd0);
  assign head_data = empty ? '0 : mem_q[rd_ptr_q];

  // Illegal requests (push when full, pop when empty) are dropped here.
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q ^ do_push;
    rd_ptr_d = rd_ptr_q ^ do_pop;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
    end
    if (do_push && !do_pop) begin
      count_d = count_q + 2'd1;
    end else if (!do_push && do_pop) begin
      count_d = count_q - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEMUX_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/stream_demux.sv
// Registered 1-to-2 stream demultiplexer: buffers {sel, data} in a 2-entry FIFO
// and presents the head word on the output its sel names, in strict program order.
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  logic [WIDTH:0]   head_entry;
  logic             head_sel;
  logic [WIDTH-1:0] head_word;
  logic             fifo_full, fifo_empty;
  logic             pop0, pop1, head_pop;
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  fifo2 #(
    .ENTRY_W (WIDTH + 1)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (in_valid),
    .push_data ({in_sel, in_data}),
    .pop       (head_pop),
    .head_data (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign in_ready  = !fifo_full;
  assign head_sel  = head_entry[WIDTH];
  assign head_word = head_entry[WIDTH-1:0];

  // Only the head's selected output is live; the other reads as idle and zero.
  always_comb begin
    out0_valid = !fifo_empty && (head_sel == SEL_OUT0);
    out1_valid = !fifo_empty && (head_sel == SEL_OUT1);
    out0_data  = out0_valid ? head_word : '0;
    out1_data  = out1_valid ? head_word : '0;
    pop0       = out0_valid && out0_ready;
    pop1       = out1_valid && out1_ready;
    head_pop   = pop0 || pop1;
  end

  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (pop0) begin
      cnt0_d = cnt0_q + 1'b1;
    end
    if (pop1) begin
      cnt1_d = cnt1_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;

endmodule

// File: tb/tb_stream_demux.sv
// Self-checking bench for stream_demux: directed scenarios plus random traffic,
// compared every cycle against a queue-based model of the demultiplexer.
module tb_stream_demux;

  localparam int WIDTH = 32;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out0_data;
  logic             out0_valid;
  logic             out0_ready;
  logic [WIDTH-1:0] out1_data;
  logic             out1_valid;
  logic             out1_ready;
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;

  int assert_count;
  int fail_count;

  logic [WIDTH:0] model_q[$];
  int             model_cnt0;
  int             model_cnt1;

  stream_demux #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out0_data  (out0_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .cnt0       (cnt0),
    .cnt1       (cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    assert_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Expected outputs follow directly from the model queue head and delivery counts.
  task automatic compareAll();
    logic [WIDTH:0]   head;
    logic             exp_v0, exp_v1;
    logic [WIDTH-1:0] exp_d0, exp_d1;
    exp_v0 = 1'b0;
    exp_v1 = 1'b0;
    exp_d0 = '0;
    exp_d1 = '0;
    if (model_q.size() > 0) begin
      head = model_q[0];
      if (head[WIDTH]) begin
        exp_v1 = 1'b1;
        exp_d1 = head[WIDTH-1:0];
      end else begin
        exp_v0 = 1'b1;
        exp_d0 = head[WIDTH-1:0];
      end
    end
    checkOutput("in_ready", 64'(in_ready), 64'(model_q.size() < 2));
    checkOutput("out0_valid", 64'(out0_valid), 64'(exp_v0));
    checkOutput("out1_valid", 64'(out1_valid), 64'(exp_v1));
    checkOutput("out0_data", 64'(out0_data), 64'(exp_d0));
    checkOutput("out1_data", 64'(out1_data), 64'(exp_d1));
    checkOutput("cnt0", 64'(cnt0), 64'(model_cnt0 % (1 << CNT_W)));
    checkOutput("cnt1", 64'(cnt1), 64'(model_cnt1 % (1 << CNT_W)));
  endtask

  // One clock cycle: called just after a falling edge, returns just after the next one.
  task automatic applyStimulus(input logic v, input logic s, input logic [WIDTH-1:0] d,
                               input logic r0, input logic r1);
    logic           do_push, do_pop;
    logic [WIDTH:0] head;
    in_valid   = v;
    in_sel     = s;
    in_data    = d;
    out0_ready = r0;
    out1_ready = r1;
    do_push = v && (model_q.size() < 2);
    do_pop  = 1'b0;
    head    = '0;
    if (model_q.size() > 0) begin
      head   = model_q[0];
      do_pop = head[WIDTH] ? r1 : r0;
    end
    @(posedge clk);
    if (do_pop) begin
      void'(model_q.pop_front());
      if (head[WIDTH]) model_cnt1++;
      else model_cnt0++;
    end
    if (do_push) model_q.push_back({s, d});
    @(negedge clk);
    #1;
    compareAll();
  endtask

  task automatic doReset();
    @(negedge clk);
    in_valid   = 1'b0;
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    rst_n      = 1'b0;
    model_q.delete();
    model_cnt0 = 0;
    model_cnt1 = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    compareAll();
  endtask

  initial begin
    logic [WIDTH-1:0] w [3];
    assert_count = 0;
    fail_count   = 0;
    model_cnt0   = 0;
    model_cnt1   = 0;
    rst_n        = 1'b0;
    in_valid     = 1'b0;
    in_sel       = 1'b0;
    in_data      = '0;
    out0_ready   = 1'b0;
    out1_ready   = 1'b0;

    doReset();
    checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
    checkOutput("reset_valids", 64'({out0_valid, out1_valid}), 64'd0);
    checkOutput("reset_cnts", 64'({cnt0, cnt1}), 64'd0);

    applyStimulus(1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 1'b1);
    checkOutput("route_out1_data", 64'(out1_data), 64'h0000_0000_DEAD_BEEF);
    checkOutput("route_out0_valid", 64'(out0_valid), 64'd0);
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);
    checkOutput("route_cnt1", 64'(cnt1), 64'd1);

    doReset();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'(i % 2), $urandom, 1'b1, 1'b1);
      checkOutput("thru_in_ready", 64'(in_ready), 64'd1);
    end
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1);
    checkOutput("thru_cnt0", 64'(cnt0), 64'd4);
    checkOutput("thru_cnt1", 64'(cnt1), 64'd4);

    doReset();
    for (int i = 0; i < 3; i++) begin
      w[i] = $urandom;
      applyStimulus(1'b1, 1'b0, w[i], 1'b0, 1'b0);
    end
    checkOutput("full_in_ready", 64'(in_ready), 64'd0);
    checkOutput("full_head", 64'(out0_data), 64'(w[0]));
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0);
    checkOutput("full_ready_back", 64'(in_ready), 64'd1);
    checkOutput("full_second", 64'(out0_data), 64'(w[1]));
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0);
    checkOutput("full_drained", 64'(out0_valid), 64'd0);

    doReset();
    applyStimulus(1'b1, 1'b0, 32'hAAAA_0001, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 32'hBBBB_0002, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);
      checkOutput("hol_out1_blocked", 64'(out1_valid), 64'd0);
    end
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0);
    checkOutput("hol_b_visible", 64'(out1_data), 64'h0000_0000_BBBB_0002);
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);

    // Reset asserted away from any clock edge with two words buffered.
    doReset();
    applyStimulus(1'b1, 1'($urandom), $urandom, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'($urandom), $urandom, 1'b0, 1'b0);
    #3;
    rst_n = 1'b0;
    model_q.delete();
    model_cnt0 = 0;
    model_cnt1 = 0;
    #1;
    checkOutput("midrst_valids", 64'({out0_valid, out1_valid}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    compareAll();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1);
    end

    doReset();
    for (int i = 0; i < 17; i++) begin
      applyStimulus(1'b1, 1'b0, $urandom, 1'b1, 1'b1);
    end
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1);
    checkOutput("wrap_cnt0", 64'(cnt0), 64'd1);
    checkOutput("wrap_cnt1", 64'(cnt1), 64'd0);

    doReset();
    for (int i = 0; i < 1500; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
